// File: rtl/occ_pkg.sv
// rtl/occ_pkg.sv - shared FSM type, datapath widths, scale constant and clamp helper
package occ_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL,
        ST_SUM,
        ST_DIV,
        ST_CLAMP
    } occ_state_t;

    localparam int NUM_W = 48;
    localparam int DEN_W = 36;

    // Voltage terms are scaled by 1e6 so that L in nH and fs in kHz land in whole clk cycles
    localparam longint SCALE_1E6 = 64'sd1000000;

    // Maps the divider outcome onto a publishable charging time
    function automatic logic [15:0] occ_clamp(
        input logic        n_pos,
        input logic        ovf,
        input logic [31:0] q,
        input logic [15:0] t_max,
        input logic [15:0] t_min
    );
        logic [15:0] res;
        if (!n_pos) begin
            res = '0;
        end else if (ovf || (q > {16'd0, t_max})) begin
            res = t_max;
        end else if (q < {16'd0, t_min}) begin
            res = '0;
        end else begin
            res = q[15:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/occ_multiphase_engine_div.sv
// rtl/occ_multiphase_engine_div.sv - restoring unsigned sequential divider, one quotient bit per cycle
module occ_seq_divider #(
    parameter int NUM_W = 48,
    parameter int DEN_W = 36,
    parameter int QW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [NUM_W-1:0] i_num,
    input  logic [DEN_W-1:0] i_den,
    output logic             o_done,
    output logic             o_ovf,
    output logic [QW-1:0]    o_quot
);

    // Upper numerator part that seeds the remainder; it must fit DEN_W when there is no overflow
    localparam int HW    = NUM_W - QW;
    localparam int CNT_W = $clog2(QW + 1);

    logic [HW-1:0]    w_hi;
    logic             w_ovf_chk;
    logic [DEN_W-1:0] w_rem_in;
    logic [DEN_W-1:0] w_den_in;
    logic             w_bit_in;
    logic [DEN_W:0]   w_trial;
    logic             w_qbit;
    logic [DEN_W-1:0] w_rem_out;

    logic [DEN_W-1:0] r_rem;
    logic [DEN_W-1:0] r_den;
    logic [QW-1:0]    r_nlo;
    logic [QW-1:0]    r_quot;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;

    // One restoring step; the start cycle already performs the first quotient bit
    always_comb begin
        w_hi      = i_num[NUM_W-1:QW];
        w_ovf_chk = ({{DEN_W{1'b0}}, w_hi} >= {{HW{1'b0}}, i_den});
        w_rem_in  = i_start ? DEN_W'(w_hi) : r_rem;
        w_bit_in  = i_start ? i_num[QW-1] : r_nlo[QW-1];
        w_den_in  = i_start ? i_den : r_den;
        w_trial   = {w_rem_in, w_bit_in};
        w_qbit    = (w_trial >= {1'b0, w_den_in});
        w_rem_out = w_qbit ? DEN_W'(w_trial - {1'b0, w_den_in}) : w_trial[DEN_W-1:0];
    end

    // Iteration state: QW steps in total, done pulses with the final quotient
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_nlo  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= w_rem_out;
                r_den  <= i_den;
                r_nlo  <= {i_num[QW-2:0], 1'b0};
                r_quot <= {{(QW-1){1'b0}}, w_qbit};
                r_ovf  <= w_ovf_chk;
                r_cnt  <= CNT_W'(QW - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem  <= w_rem_out;
                r_nlo  <= {r_nlo[QW-2:0], 1'b0};
                r_quot <= {r_quot[QW-2:0], w_qbit};
                r_cnt  <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_ovf  = r_ovf;
    assign o_quot = r_quot;

endmodule

// File: rtl/occ_multiphase_engine.sv
// rtl/occ_multiphase_engine.sv - N-channel one-cycle-control engine; FIXED_VGAP_EN forces the gap voltage to VGAP_FIXED
module occ_multiphase_engine
    import occ_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int VIN        = 120,
    parameter int L_NH       = 3300,
    parameter int FS_KHZ     = 250,
    parameter int TS_CLK     = 400,
    parameter int T_MAX_CLK  = 200,
    parameter int T_MIN_CLK  = 4,
    parameter int IREF_MAX   = 50,
    parameter int QW         = 16,
    parameter int VGAP_FIXED = 25
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      period_start,
    input  logic [16*N_CH-1:0]   sample_current,
    input  logic [16*N_CH-1:0]   sample_voltage,
    input  logic [15:0]          i_set,
    input  logic                 err_clr,
    output logic [16*N_CH-1:0]   ton,
    output logic [N_CH-1:0]      ton_valid,
    output logic                 busy,
    output logic [N_CH-1:0]      err_overrun,
    output logic [N_CH-1:0]      err_vgap
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int SH   = $clog2(N_CH);

    localparam logic signed [63:0] C_A = SCALE_1E6 * 64'(TS_CLK);
    localparam logic signed [63:0] C_B = 64'(2) * 64'(VIN) * 64'(L_NH) * 64'(FS_KHZ) * 64'(TS_CLK);
    localparam logic signed [63:0] C_D = 64'(2) * 64'(VIN) * SCALE_1E6;

    // Every channel must be serviceable within one switching period
    generate
        if (N_CH * (5 + QW) > TS_CLK) begin : g_budget_err
            $error("N_CH*(5+QW) exceeds TS_CLK");
        end
        if (VGAP_FIXED >= VIN) begin : g_fixed_vgap_err
            $error("VGAP_FIXED must be below VIN");
        end
    endgenerate

    occ_state_t r_state;
    occ_state_t w_next;

    logic [N_CH-1:0]        r_pending;
    logic [N_CH-1:0][15:0]  r_snap_id;
    logic [N_CH-1:0][15:0]  r_snap_vg;
    logic [N_CH-1:0][15:0]  r_ton;
    logic [N_CH-1:0]        r_ton_valid;
    logic [N_CH-1:0]        r_err_ov;
    logic [N_CH-1:0]        r_err_vg;

    logic [CH_W-1:0]        r_ch;
    logic [15:0]            r_vgap;
    logic signed [17:0]     r_vd;
    logic signed [17:0]     r_di;
    logic signed [63:0]     r_a;
    logic signed [63:0]     r_b;
    logic [DEN_W-1:0]       r_d;
    logic                   r_npos;

    logic [16*N_CH-1:0]     w_vg_src;
    logic [CH_W-1:0]        w_sel;
    logic [15:0]            w_sel_id;
    logic [15:0]            w_sel_vg;
    logic [15:0]            w_iref_sh;
    logic [15:0]            w_iref;
    logic signed [17:0]     w_vd;
    logic signed [17:0]     w_di;
    logic                   w_vd_bad;
    logic signed [63:0]     w_vg64;
    logic signed [63:0]     w_vd64;
    logic signed [63:0]     w_di64;
    logic signed [63:0]     w_num;
    logic [N_CH-1:0]        w_take;
    logic [N_CH-1:0]        w_vgap_set;
    logic                   w_div_start;
    logic                   w_div_done;
    logic                   w_div_ovf;
    logic [QW-1:0]          w_div_quot;
    logic                   w_pub;
    logic [CH_W-1:0]        w_pub_ch;
    logic [15:0]            w_pub_val;

`ifdef FIXED_VGAP_EN
    assign w_vg_src = {N_CH{16'(VGAP_FIXED)}};
`else
    assign w_vg_src = sample_voltage;
`endif

    // Snapshot each channel on its strobe; a newer strobe simply overwrites the older sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_id <= '0;
            r_snap_vg <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (period_start[c]) begin
                    r_snap_id[c] <= sample_current[16*c+15] ? 16'd0 : sample_current[16*c +: 16];
                    r_snap_vg[c] <= w_vg_src[16*c +: 16];
                end
            end
        end
    end

    // Lowest-index pending channel and the LOAD-stage operands derived from it
    always_comb begin
        w_sel = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (r_pending[c]) begin
                w_sel = CH_W'(c);
            end
        end
        w_sel_id  = r_snap_id[w_sel];
        w_sel_vg  = r_snap_vg[w_sel];
        w_iref_sh = i_set >> SH;
        w_iref    = (w_iref_sh > 16'(IREF_MAX)) ? 16'(IREF_MAX) : w_iref_sh;
        w_vd      = 18'(VIN) - $signed({2'b00, w_sel_vg});
        w_di      = $signed({2'b00, w_iref}) - $signed({2'b00, w_sel_id});
        w_vd_bad  = (w_vd <= 18'sd0);
        w_vg64    = $signed({48'd0, r_vgap});
        w_vd64    = 64'(r_vd);
        w_di64    = 64'(r_di);
        w_num     = r_a + r_b;
    end

    // Channel consumed by LOAD and the gap-voltage error it may raise
    always_comb begin
        w_take     = '0;
        w_vgap_set = '0;
        if (r_state == ST_LOAD) begin
            w_take = N_CH'(1) << w_sel;
            if (w_vd_bad) begin
                w_vgap_set = w_take;
            end
        end
    end

    // Pending flags and sticky errors; a same-cycle set beats err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_err_ov  <= '0;
            r_err_vg  <= '0;
        end else begin
            r_pending <= (r_pending & ~w_take) | period_start;
            r_err_ov  <= (err_clr ? '0 : r_err_ov) | (period_start & r_pending & ~w_take);
            r_err_vg  <= (err_clr ? '0 : r_err_vg) | w_vgap_set;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, divider start and publish decision
    always_comb begin
        w_next      = r_state;
        w_div_start = 1'b0;
        w_pub       = 1'b0;
        w_pub_ch    = r_ch;
        w_pub_val   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_vd_bad) begin
                    w_pub    = 1'b1;
                    w_pub_ch = w_sel;
                    w_next   = ST_CLAMP;
                end else begin
                    w_next = ST_MUL;
                end
            end
            ST_MUL: begin
                w_next = ST_SUM;
            end
            ST_SUM: begin
                w_div_start = 1'b1;
                w_next      = ST_DIV;
            end
            ST_DIV: begin
                if (w_div_done) begin
                    w_pub     = 1'b1;
                    w_pub_val = occ_clamp(r_npos, w_div_ovf, 32'(w_div_quot),
                                          16'(T_MAX_CLK), 16'(T_MIN_CLK));
                    w_next    = ST_CLAMP;
                end
            end
            ST_CLAMP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Arithmetic pipeline registers for LOAD, MUL and SUM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch   <= '0;
            r_vgap <= '0;
            r_vd   <= '0;
            r_di   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_d    <= '0;
            r_npos <= 1'b0;
        end else begin
            if (r_state == ST_LOAD) begin
                r_ch   <= w_sel;
                r_vgap <= w_sel_vg;
                r_vd   <= w_vd;
                r_di   <= w_di;
            end
            if (r_state == ST_MUL) begin
                r_a <= w_vg64 * w_vd64 * C_A;
                r_b <= w_di64 * C_B;
                r_d <= DEN_W'(w_vd64 * C_D);
            end
            if (r_state == ST_SUM) begin
                r_npos <= (w_num > 64'sd0);
            end
        end
    end

    // Published charging times; ton_valid is high for the single cycle after a write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ton       <= '0;
            r_ton_valid <= '0;
        end else begin
            r_ton_valid <= '0;
            if (w_pub) begin
                r_ton[w_pub_ch]       <= w_pub_val;
                r_ton_valid[w_pub_ch] <= 1'b1;
            end
        end
    end

    occ_seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W),
        .QW    (QW)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_div_start),
        .i_num   (w_num[NUM_W-1:0]),
        .i_den   (r_d),
        .o_done  (w_div_done),
        .o_ovf   (w_div_ovf),
        .o_quot  (w_div_quot)
    );

    assign ton         = r_ton;
    assign ton_valid   = r_ton_valid;
    assign busy        = (r_state != ST_IDLE);
    assign err_overrun = r_err_ov;
    assign err_vgap    = r_err_vg;

endmodule

// File: tb/tb_occ_multiphase_engine.sv
// tb/tb_occ_multiphase_engine.sv - scoreboard bench for occ_multiphase_engine
module tb_occ_multiphase_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  period_start = '0;
    logic [31:0] sample_current = '0;
    logic [31:0] sample_voltage = '0;
    logic [15:0] i_set = 16'd40;
    logic        err_clr = 1'b0;
    logic [31:0] ton;
    logic [1:0]  ton_valid;
    logic        busy;
    logic [1:0]  err_overrun;
    logic [1:0]  err_vgap;

    typedef struct {
        int ch;
        int val;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_s = 0;
    int   s0 = 0;

    // ch, i_set, id, vgap, expected ton (all with 21-cycle latency)
    int v_ch[8]   = '{0, 0, 0, 0, 0, 0, 1, 0};
    int v_iset[8] = '{40, 40, 40, 200, 40, 40, 40, 40};
    int v_id[8]   = '{20, 10, 40, 0, 20, 20, 10, -5};
    int v_vg[8]   = '{25, 25, 25, 25, 2, 3, 25, 25};
    int v_exp[8]  = '{41, 76, 0, 200, 0, 5, 76, 111};

    occ_multiphase_engine dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .period_start   (period_start),
        .sample_current (sample_current),
        .sample_voltage (sample_voltage),
        .i_set          (i_set),
        .err_clr        (err_clr),
        .ton            (ton),
        .ton_valid      (ton_valid),
        .busy           (busy),
        .err_overrun    (err_overrun),
        .err_vgap       (err_vgap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_ch(input int c, input int id, input int vg);
        sample_current[16*c +: 16] = 16'(id);
        sample_voltage[16*c +: 16] = 16'(vg);
    endtask

    task automatic strobe(input logic [1:0] m);
        @(posedge clk);
        #1;
        period_start = m;
        last_s = cyc;
        @(posedge clk);
        #1;
        period_start = '0;
    endtask

    task automatic push(input int c, input int v, input int s, input int lat);
        exp_t e;
        e.ch  = c;
        e.val = v;
        e.cyc = s + lat;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    // Monitor: every ton_valid pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < 2; c++) begin
                if (ton_valid[c]) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_valid: ch%0d ton=%0d with nothing expected", c, ton[16*c +: 16]);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("valid_channel", c, mon_e.ch);
                        check($sformatf("ton_value_ch%0d", c), ton[16*c +: 16], mon_e.val);
                        check($sformatf("ton_latency_ch%0d", c), cyc, mon_e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("reset_ton", ton, 0);
        check("reset_ton_valid", ton_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_err", {err_overrun, err_vgap}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-channel directed vectors
        for (int i = 0; i < 8; i++) begin
            i_set = 16'(v_iset[i]);
            set_ch(v_ch[i], v_id[i], v_vg[i]);
            strobe(2'b01 << v_ch[i]);
            push(v_ch[i], v_exp[i], last_s, 21);
            if (i == 0) begin
                @(posedge clk);
                #1;
                check("busy_during_compute", busy, 1);
            end
            drain();
        end
        i_set = 16'd40;
        repeat (5) @(posedge clk);
        #1;
        check("ton0_holds", ton[15:0], 111);
        check("ton1_holds", ton[31:16], 76);
        check("idle_not_busy", busy, 0);

        // Gap voltage at and above VIN
        set_ch(0, 20, 120);
        strobe(2'b01);
        push(0, 0, last_s, 3);
        drain();
        check("err_vgap_ch0", err_vgap, 2'b01);
        set_ch(1, 20, 130);
        strobe(2'b10);
        push(1, 0, last_s, 3);
        drain();
        check("err_vgap_both", err_vgap, 2'b11);
        check("no_overrun_yet", err_overrun, 2'b00);
        pulse_clr();
        check("err_vgap_cleared", err_vgap, 2'b00);

        // Simultaneous strobes are serviced in channel order
        set_ch(0, 20, 25);
        set_ch(1, 10, 25);
        strobe(2'b11);
        push(0, 41, last_s, 21);
        push(1, 76, last_s, 42);
        drain();

        // Second ch1 strobe before service: overrun, latest sample wins
        set_ch(0, 20, 25);
        set_ch(1, 10, 25);
        strobe(2'b11);
        s0 = last_s;
        push(0, 41, s0, 21);
        repeat (3) @(posedge clk);
        set_ch(1, 40, 25);
        strobe(2'b10);
        push(1, 0, s0, 42);
        drain();
        check("err_overrun_ch1", err_overrun, 2'b10);

        // Reset in the middle of the divide
        set_ch(0, 10, 25);
        strobe(2'b01);
        repeat (10) @(posedge clk);
        #1;
        check("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_reset_ton", ton, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_err", {err_overrun, err_vgap}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_ch(0, 20, 25);
        strobe(2'b01);
        push(0, 41, last_s, 21);
        drain();

        repeat (30) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/occ_multiphase_engine.md
Name: occ_multiphase_engine

Overview:
- Parametrised N-channel one-cycle-control engine for interleaved buck discharge channels. It sits between the per-channel phase-shifted switching timers and the PWM generators.
- On each channel's period-start strobe it snapshots that channel's filtered current and gap voltage.
- One shared arithmetic pipeline with a sequential divider computes the inductor charging time in clk cycles for each channel in turn, then clamps and publishes it.
- Unlike the single-channel generation, the numerator is scaled by Ts before the division, which preserves precision.

Parameters:
- N_CH, 2, number of channels (1, 2, 4 or 8)
- VIN, 120, input voltage, V
- L_NH, 3300, inductance, nH
- FS_KHZ, 250, switching frequency, kHz
- TS_CLK, 400, clk cycles per switching period
- T_MAX_CLK, 200, maximum charging time, clk
- T_MIN_CLK, 4, charging times below this value are forced to 0
- IREF_MAX, 50, cap on per-channel reference current, A
- QW, 16, quotient width; divider runs QW cycles
- VGAP_FIXED, 25, fixed gap voltage used under the optional feature

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- period_start  in  N_CH  per-channel one-cycle strobe (timer == 0)
- sample_current  in  16*N_CH  signed filtered current, channel c at [16c+15:16c]
- sample_voltage  in  16*N_CH  unsigned filtered gap voltage, same packing
- i_set  in  16  total current setpoint, A
- err_clr  in  1  clears sticky errors
- ton  out  16*N_CH  charging time per channel, clk cycles
- ton_valid  out  N_CH  one-cycle pulse when ton[c] updates
- busy  out  1  engine not IDLE
- err_overrun  out  N_CH  sticky: strobe arrived while the channel was still pending
- err_vgap  out  N_CH  sticky: Vgap >= VIN seen on the channel

Behaviour:
- Reset: ton=0, ton_valid=0, busy=0, err_*=0, pending=0, FSM=IDLE.
- Capture: on period_start[c], latch id_c (negative values become 0) and vgap_c into per-channel snapshot registers and set pending[c].
  - If pending[c] is already set, overwrite the snapshot (latest wins) and set err_overrun[c].
- iref = min(i_set >> log2(N_CH), IREF_MAX), computed at LOAD.
- FSM IDLE -> LOAD -> MUL -> SUM -> DIV -> CLAMP -> IDLE.
  - IDLE: leave when any pending bit is set.
  - LOAD: pick the lowest-index pending channel and clear its pending bit. A strobe on the same channel in the same cycle wins, and pending stays set. Compute vd = VIN - vgap and di = iref - id, both signed.
  - MUL: A = vgap*vd*1e6*TS_CLK; B = 2*VIN*L_NH*FS_KHZ*di*TS_CLK; D = 2*VIN*vd*1e6.
  - SUM: N = A + B, 48-bit signed; D is 36-bit unsigned.
  - DIV: start the sub-divider and wait for done (QW cycles).
  - CLAMP: compute the result (rules below), write ton[c], pulse ton_valid[c].
- Arithmetic: no intermediate truncation.
  - vd <= 0 → result 0 and set err_vgap[c]; the divider is skipped and the FSM goes directly to CLAMP.
  - N <= 0 → result 0.
  - Quotient overflow (N >= D<<QW) or q > T_MAX_CLK → T_MAX_CLK.
  - q < T_MIN_CLK → 0.
  - Otherwise q, truncated.
- Latency (engine idle, single request): ton_valid[c] asserts exactly 5+QW cycles after the period_start[c] cycle, i.e. 21 at QW=16.
- Service time per channel is 5+QW cycles, so N_CH*(5+QW) must be <= TS_CLK. This is checked by a synthesis-time assertion.
- ton[c] holds its value between updates.
- err_clr clears all sticky bits. If err_clr and a set event occur in the same cycle, set wins.
- Asynchronous reset mid-computation aborts the computation; outputs return to reset values.

Optional Feature:
- FIXED_VGAP_EN defined: the snapshot ignores sample_voltage and uses VGAP_FIXED for every channel. This is intended for bring-up.
- Not defined: the sampled voltage is used.

Decomposition:
- Package occ_pkg holds:
  - the FSM state enum;
  - width constants (NUM_W=48, DEN_W=36);
  - the clamp function;
  - the 1e6 scale constant.
- Sub-module occ_seq_divider: restoring unsigned divider, one quotient bit per cycle.
  - Interface: start/done handshake, an overflow flag, and width parameters NUM_W, DEN_W and QW.

Test Plan:
- Steady state, N_CH=2, vgap=25, i_set=40 (iref=20), id=20, strobe ch0 → ton[0]=41, ton_valid[0] 21 cycles after the strobe.
- Boost, vgap=25, iref=20, id=10 → ton=76.
- Over-current, id=40, iref=20 → ton=0. Saturation: i_set=200 (iref capped at 50), id=0 → raw 215, ton=200.
- Vgap=120 → ton=0, err_vgap[c]=1; err_clr pulse → 0.
- Simultaneous strobes on ch0 and ch1 → ch0 valid at +21, ch1 valid at +42. A second ch1 strobe before service → err_overrun[1]=1 and the latest sample is used.
- Reset asserted during DIV → outputs 0 immediately. After release, a new strobe produces a correct result.
